// File: rtl/uart_crypto_bridge.sv
// Command-framed byte bridge between the UART byte layer and a block-cipher core.
// Optional macro RESP_HEADER_EN prefixes every response with a status byte (A5 / 5A).
module uart_crypto_bridge #(
    parameter int          KEY_BITS       = 256,
    parameter int          BLK_BITS       = 128,
    parameter int          TIMEOUT_CYCLES = 8700,
    parameter logic [7:0]  CMD_KEY        = 8'h4B,
    parameter logic [7:0]  CMD_BLK        = 8'h44,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE,
    parameter int          CNT_W          = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rx_valid,
    input  logic [7:0]          rx_byte,
    output logic [7:0]          tx_byte,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic                core_start,
    output logic [KEY_BITS-1:0] core_key,
    output logic [BLK_BITS-1:0] core_din,
    input  logic [BLK_BITS-1:0] core_dout,
    input  logic                core_ready,
    output logic                key_valid,
    output logic                busy,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);
    localparam int KEY_BYTES = KEY_BITS / 8;
    localparam int BLK_BYTES = BLK_BITS / 8;
    localparam int MAX_BYTES = (KEY_BYTES > BLK_BYTES + 1) ? KEY_BYTES : BLK_BYTES + 1;
    localparam int IDX_W     = $clog2(MAX_BYTES);
    localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, RX_KEY, RX_BLK, START, WAIT, TX_LOAD, TX_WAIT, TX_ERR
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    tx_last;
    logic [TMO_W-1:0]    idle_cnt;
    logic                tx_first;
    // One spare byte so an optional status header can sit in front of the payload.
    logic [BLK_BITS+7:0] tx_buf;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            tx_last    <= '0;
            idle_cnt   <= '0;
            tx_first   <= 1'b0;
            tx_buf     <= '0;
            tx_byte    <= '0;
            tx_start   <= 1'b0;
            core_start <= 1'b0;
            core_key   <= '0;
            core_din   <= '0;
            key_valid  <= 1'b0;
            err_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            tx_start   <= 1'b0;
            core_start <= 1'b0;
            case (state)
                IDLE: if (rx_valid) begin
                    idx      <= '0;
                    idle_cnt <= '0;
                    if (rx_byte == CMD_KEY) begin
                        key_valid <= 1'b0;
                        state     <= RX_KEY;
                    end else if (rx_byte == CMD_BLK) begin
                        state <= RX_BLK;
                    end else begin
                        err_cnt <= sat_inc(err_cnt);
                    end
                end
                RX_KEY, RX_BLK: begin
                    // A byte arriving on the expiry cycle still counts.
                    if (rx_valid) begin
                        idle_cnt <= '0;
                        idx      <= idx + 1'b1;
                        if (state == RX_KEY) begin
                            core_key[8*idx +: 8] <= rx_byte;
                            if (idx == IDX_W'(KEY_BYTES - 1)) begin
                                key_valid <= 1'b1;
                                idx       <= '0;
                                state     <= IDLE;
                            end
                        end else begin
                            core_din[8*idx +: 8] <= rx_byte;
                            if (idx == IDX_W'(BLK_BYTES - 1)) begin
                                idx <= '0;
                                if (key_valid) begin
                                    core_start <= 1'b1;
                                    state      <= START;
                                end else begin
                                    state <= TX_ERR;
                                end
                            end
                        end
                    end else if (idle_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        idx     <= '0;
                        err_cnt <= sat_inc(err_cnt);
                        state   <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                START: state <= WAIT;
                WAIT: if (core_ready) begin
`ifdef RESP_HEADER_EN
                    tx_buf  <= {core_dout, 8'hA5};
                    tx_last <= IDX_W'(BLK_BYTES);
`else
                    tx_buf  <= {8'h00, core_dout};
                    tx_last <= IDX_W'(BLK_BYTES - 1);
`endif
                    idx   <= '0;
                    state <= TX_LOAD;
                end
                TX_ERR: begin
`ifdef RESP_HEADER_EN
                    tx_buf  <= {{(BLK_BITS-8){1'b0}}, ERR_BYTE, 8'h5A};
                    tx_last <= IDX_W'(1);
`else
                    tx_buf  <= {{BLK_BITS{1'b0}}, ERR_BYTE};
                    tx_last <= '0;
`endif
                    idx   <= '0;
                    state <= TX_LOAD;
                end
                TX_LOAD: if (!tx_busy) begin
                    tx_byte  <= tx_buf[8*idx +: 8];
                    tx_start <= 1'b1;
                    tx_first <= 1'b1;
                    state    <= TX_WAIT;
                end
                TX_WAIT: begin
                    // tx_busy only rises the cycle after tx_start.
                    if (tx_first) begin
                        tx_first <= 1'b0;
                    end else if (!tx_busy) begin
                        if (idx == tx_last) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= TX_LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (rx_valid && (state inside {START, WAIT, TX_LOAD, TX_WAIT, TX_ERR}))
                drop_cnt <= sat_inc(drop_cnt);
        end
    end
endmodule

// File: tb/tb_uart_crypto_bridge.sv
// Randomized bench for uart_crypto_bridge: byte-level reference model, cipher and UART-tx models.
module tb_uart_crypto_bridge;
    localparam int KB  = 32;
    localparam int BB  = 16;
    localparam int TMO = 8700;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_byte = 8'h00;
    logic [7:0]   tx_byte;
    logic         tx_start;
    logic         tx_busy;
    logic         core_start;
    logic [255:0] core_key;
    logic [127:0] core_din;
    logic [127:0] core_dout = '0;
    logic         core_ready = 1'b0;
    logic         key_valid;
    logic         busy;
    logic [7:0]   err_cnt;
    logic [7:0]   drop_cnt;

    always #5 clk = ~clk;

    uart_crypto_bridge dut (
        .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
        .core_start(core_start), .core_key(core_key), .core_din(core_din),
        .core_dout(core_dout), .core_ready(core_ready), .key_valid(key_valid),
        .busy(busy), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
    );

    // Transmitter: busy rises the cycle after tx_start and lasts a random byte time.
    int busy_left = 0;
    always @(posedge clk) begin
        if (tx_start) busy_left <= int'($urandom_range(2, 6));
        else if (busy_left > 0) busy_left <= busy_left - 1;
    end
    assign tx_busy = (busy_left != 0);

    // Cipher stand-in: result = din ^ key[127:0], ready pulse 14 cycles after start.
    int           core_cnt = 0;
    logic [127:0] core_cap = '0;
    always @(posedge clk) begin
        core_ready <= 1'b0;
        if (core_start) begin
            core_cnt <= 14;
            core_cap <= core_din ^ core_key[127:0];
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_ready <= 1'b1;
                core_dout  <= core_cap;
            end
        end
    end

    logic [7:0] txq[$];
    int         n_start = 0;
    always @(negedge clk) begin
        if (tx_start) txq.push_back(tx_byte);
        if (core_start) n_start++;
    end

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    logic [7:0] mkey[KB];
    bit         mkey_ok = 0;
    int         exp_err = 0, exp_drop = 0;

    task automatic rx_send(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] pl[$], input int long_at);
        rx_send(cmd, int'($urandom_range(0, 3)));
        for (int i = 0; i < pl.size(); i++)
            rx_send(pl[i], (i == long_at) ? TMO - 1 : ((i == pl.size() - 1) ? 0 : int'($urandom_range(0, 3))));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        mkey_ok = 0; exp_err = 0; exp_drop = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_txb"}, 256'(tx_byte), 256'(0));
        chk({tag, "_txs"}, 256'(tx_start), 256'(0));
        chk({tag, "_cst"}, 256'(core_start), 256'(0));
        chk({tag, "_key"}, core_key, 256'(0));
        chk({tag, "_din"}, 256'(core_din), 256'(0));
        chk({tag, "_kv"},  256'(key_valid), 256'(0));
        chk({tag, "_bsy"}, 256'(busy), 256'(0));
        chk({tag, "_err"}, 256'(err_cnt), 256'(0));
        chk({tag, "_drp"}, 256'(drop_cnt), 256'(0));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin @(negedge clk); n++; end
        chk({tag, "_idle"}, 256'(busy), 256'(0));
    endtask

    task automatic run_key(input logic [7:0] k[$], input int long_at);
        logic [255:0] ek;
        int base = txq.size();
        send_frame(8'h4B, k, long_at);
        for (int i = 0; i < KB; i++) begin mkey[i] = k[i]; ek[8*i +: 8] = k[i]; end
        mkey_ok = 1;
        chk("key_valid", 256'(key_valid), 256'(1));
        chk("key_value", core_key, ek);
        chk("key_notx", 256'(txq.size() - base), 256'(0));
    endtask

    task automatic run_block(input string tag, input logic [7:0] d[$], input int inject);
        logic [7:0] exp[$];
        int base = txq.size();
        int s0 = n_start;
        int n = 0;
`ifdef RESP_HEADER_EN
        exp.push_back(mkey_ok ? 8'hA5 : 8'h5A);
`endif
        if (mkey_ok) for (int i = 0; i < BB; i++) exp.push_back(d[i] ^ mkey[i]);
        else exp.push_back(8'hEE);
        send_frame(8'h44, d, -1);
        if (inject > 0) begin
            while (txq.size() == base && n < 500) begin @(negedge clk); n++; end
            for (int i = 0; i < inject; i++) rx_send(8'($urandom), 1);
            exp_drop += inject;
        end
        wait_idle(tag, 3000);
        chk({tag, "_len"}, 256'(txq.size() - base), 256'(exp.size()));
        for (int i = 0; i < exp.size() && base + i < txq.size(); i++)
            chk({tag, "_byte"}, 256'(txq[base + i]), 256'(exp[i]));
        chk({tag, "_nstart"}, 256'(n_start - s0), 256'(mkey_ok ? 1 : 0));
        chk({tag, "_err"}, 256'(err_cnt), 256'(exp_err));
        chk({tag, "_drop"}, 256'(drop_cnt), 256'(exp_drop));
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] d[$];
        int k;
        repeat (3) @(negedge clk);
        do_reset();
        check_zero("rst");

        // Block with no key: error response, no core start
        d = {}; for (int i = 0; i < BB; i++) d.push_back(8'($urandom));
        run_block("nokey", d, 0);

        // Directed key 00..1F and block 20..2F
        q = {}; for (int i = 0; i < KB; i++) q.push_back(8'(i));
        run_key(q, -1);
        d = {}; for (int i = 0; i < BB; i++) d.push_back(8'(8'h20 + i));
        run_block("dir", d, 0);

        // Random keys and blocks
        for (int r = 0; r < 3; r++) begin
            q = {}; for (int i = 0; i < KB; i++) q.push_back(8'($urandom));
            run_key(q, -1);
            for (int b = 0; b < 3; b++) begin
                d = {}; for (int i = 0; i < BB; i++) d.push_back(8'($urandom));
                run_block("rnd", d, 0);
            end
        end

        // Unknown command, then bytes dropped during TX
        rx_send(8'h77, 1);
        exp_err++;
        chk("unk_err", 256'(err_cnt), 256'(exp_err));
        d = {}; for (int i = 0; i < BB; i++) d.push_back(8'($urandom));
        run_block("drop", d, 3);

        // Byte arriving exactly on the timeout cycle is still accepted
        do_reset();
        q = {}; for (int i = 0; i < KB; i++) q.push_back(8'($urandom));
        run_key(q, 3);
        chk("edge_err", 256'(err_cnt), 256'(0));

        // Timeout after 5 key bytes
        do_reset();
        q = {}; for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
        send_frame(8'h4B, q, -1);
        k = 0;
        while (busy && k < TMO + 20) begin @(negedge clk); k++; end
        chk("tmo_cycles", 256'(k), 256'(TMO));
        chk("tmo_err", 256'(err_cnt), 256'(1));
        chk("tmo_kv", 256'(key_valid), 256'(0));
        chk("tmo_partial", 256'(core_key[39:0]), 256'({q[4], q[3], q[2], q[1], q[0]}));

        // Reset while waiting on the core
        q = {}; for (int i = 0; i < KB; i++) q.push_back(8'($urandom));
        run_key(q, -1);
        d = {}; for (int i = 0; i < BB; i++) d.push_back(8'($urandom));
        k = n_start;
        send_frame(8'h44, d, -1);
        repeat (4) @(negedge clk);
        chk("wait_started", 256'(n_start - k), 256'(1));
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("midrst");
        reset_n = 1'b1;
        mkey_ok = 0; exp_err = 0; exp_drop = 0;
        repeat (20) @(negedge clk);
        q = {}; for (int i = 0; i < KB; i++) q.push_back(8'(i));
        run_key(q, -1);
        d = {}; for (int i = 0; i < BB; i++) d.push_back(8'($urandom));
        run_block("post", d, 0);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) rx_send(8'h77, 0);
        chk("err_sat", 256'(err_cnt), 256'(255));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
